// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  stallreq_o
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic                 rsel_q, rsel_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d;
  logic [W-1:0]         quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, res_q, res_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic         sgn_in, a_neg, b_neg, div0, ovf, start_ok, last_it, fit, hit;
  logic [W-1:0] a_abs, b_abs, it_quo, it_rem, fin_quo, fin_rem;
  logic [W:0]   rem_sh, diff;

  assign sgn_in   = ~op_i[0];
  assign a_neg    = sgn_in & dividend_i[W-1];
  assign b_neg    = sgn_in & divisor_i[W-1];
  assign a_abs    = a_neg ? -dividend_i : dividend_i;
  assign b_abs    = b_neg ? -divisor_i : divisor_i;
  assign div0     = (divisor_i == '0);
  assign ovf      = sgn_in & (dividend_i == {1'b1, {(W-1){1'b0}}}) & (&divisor_i);
  assign start_ok = (state_q == IDLE) & start_i & ~flush_i;
  assign last_it  = (state_q == CALC) & (cnt_q == CNT_WIDTH'(W-1));

  // Borrow out of the W+1-bit trial subtract is the sign of the difference.
  assign rem_sh  = {rem_q, quo_q[W-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign fit     = ~diff[W];
  assign it_quo  = {quo_q[W-2:0], fit};
  assign it_rem  = fit ? diff[W-1:0] : rem_sh[W-1:0];
  assign fin_quo = qneg_q ? -it_quo : it_quo;
  assign fin_rem = rneg_q ? -it_rem : it_rem;

`ifdef DIV_RESULT_CACHE_EN
  logic         c_vld_q, c_sgn_q;
  logic [W-1:0] c_dvd_q, c_dvs_q, c_quo_q, c_rem_q;

  assign hit = c_vld_q & (dividend_i == c_dvd_q) & (divisor_i == c_dvs_q) & (sgn_in == c_sgn_q);

  // Operand key is captured at launch; valid is raised once the results exist.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      c_dvd_q <= '0;
      c_dvs_q <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
    end else if (start_ok & ~hit) begin
      c_dvd_q <= dividend_i;
      c_dvs_q <= divisor_i;
      c_sgn_q <= sgn_in;
      c_vld_q <= div0 | ovf;
      c_quo_q <= div0 ? '1 : dividend_i;
      c_rem_q <= div0 ? dividend_i : '0;
    end else if (last_it & ~flush_i) begin
      c_vld_q <= 1'b1;
      c_quo_q <= fin_quo;
      c_rem_q <= fin_rem;
    end else if ((state_q == CALC) & flush_i) begin
      c_vld_q <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rsel_d  = rsel_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start_ok) begin
        rsel_d = op_i[1];
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        quo_d  = a_abs;
        rem_d  = '0;
        dvs_d  = b_abs;
        cnt_d  = '0;
        state_d = DONE;
        if (div0)     res_d = op_i[1] ? dividend_i : '1;
        else if (ovf) res_d = op_i[1] ? '0 : dividend_i;
`ifdef DIV_RESULT_CACHE_EN
        else if (hit) res_d = op_i[1] ? c_rem_q : c_quo_q;
`endif
        else          state_d = CALC;
      end
      CALC: begin
        quo_d = it_quo;
        rem_d = it_rem;
        cnt_d = cnt_q + 1'b1;
        if (last_it) begin
          state_d = DONE;
          res_d   = rsel_q ? fin_rem : fin_quo;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rsel_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign result_o   = res_q;
  assign stallreq_o = (start_i & (state_q == IDLE)) | (busy_o & ~done_o);
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed RV32M corner cases plus random ops.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic          clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, flush_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [W-1:0]  dividend_i = '0, divisor_i = '0;
  logic          busy_o, done_o, stallreq_o;
  logic [W-1:0]  result_o;

  div_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .stallreq_o(stallreq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [1:0]  op;
    logic [31:0] a, b;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          nvec = 0, nerr = 0;
  logic [31:0] last_res = '0;
  bit          cv = 0, cs = 0;
  logic [31:0] ca = '0, cb = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == MIN && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : MIN;
      sa = a; sb = b;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin @(negedge clk_i); n++; end
    if (n >= 200) begin
      nvec++; nerr++;
      $display("FAIL idle_wait: busy_o still 1 after %0d cycles", n);
    end
  endtask

  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    bit sp, hit;
    int lat;
    exp_t e;
    wait_idle();
    sp  = (b == 0) || (!op[0] && a == MIN && b == 32'hFFFF_FFFF);
`ifdef DIV_RESULT_CACHE_EN
    hit = cv && (ca == a) && (cb == b) && (cs == !op[0]);
`else
    hit = 0;
`endif
    lat = (sp || hit) ? 1 : W + 1;
    op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
    e.res = model(op, a, b); e.cyc = cyc + lat; e.op = op; e.a = a; e.b = b;
    q.push_back(e);
    cv = 1; ca = a; cb = b; cs = !op[0];
    last_res = e.res;
    @(negedge clk_i);
    start_i = 1'b0;
    // scramble operands to show they were latched
    dividend_i = $urandom; divisor_i = $urandom; op_i = 2'($urandom);
  endtask

  // Monitor: pops one expectation per done_o pulse.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (done_o) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_done: got done_o=1 result %h, expected no completion", result_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("result op%0d %h/%h", e.op, e.a, e.b), result_o, e.res);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("stallreq_in_done", {31'b0, stallreq_o}, 32'h0);
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        nvec++; nerr++;
        $display("FAIL done_timeout: got no done_o by cycle %0d, expected at %0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int c0;
    logic [1:0] op;
    logic [31:0] a, b, pa, pb;
    #1;
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_done", {31'b0, done_o}, 32'h0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_stallreq", {31'b0, stallreq_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    issue(2'b01, 100, 7);
    issue(2'b11, 100, 7);
    issue(2'b00, 32'hFFFF_FFF9, 2);
    issue(2'b10, 32'hFFFF_FFF9, 2);
    issue(2'b00, 5, 0);
    issue(2'b10, 5, 0);
    issue(2'b01, MIN, 0);
    issue(2'b00, MIN, 32'hFFFF_FFFF);
    issue(2'b10, MIN, 32'hFFFF_FFFF);
    issue(2'b01, MIN, 32'hFFFF_FFFF);

    // Flush during CALC
    wait_idle();
    c0 = cyc;
    op_i = 2'b01; dividend_i = 1000; divisor_i = 3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cv = 0;
    while (cyc < c0 + 10) @(negedge clk_i);
    chk("stallreq_calc", {31'b0, stallreq_o}, 32'h1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy", {31'b0, busy_o}, 32'h0);
    chk("flush_done", {31'b0, done_o}, 32'h0);
    chk("flush_result_hold", result_o, last_res);

    // Flush together with start in IDLE: start rejected
    op_i = 2'b01; dividend_i = 50; divisor_i = 5; start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_rejected", {31'b0, busy_o}, 32'h0);
    issue(2'b01, 9, 3);

    // Asynchronous reset mid-operation
    wait_idle();
    c0 = cyc;
    issue(2'b00, 32'h0123_4567, 32'h89);
    while (cyc < c0 + 5) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy_o}, 32'h0);
    chk("arst_done", {31'b0, done_o}, 32'h0);
    chk("arst_result", result_o, 32'h0);
    q.delete();
    cv = 0; last_res = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    issue(2'b01, 100, 7);

    pa = 32'd12345; pb = 32'd67;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = MIN; b = 32'hFFFF_FFFF; end
        2, 3: begin a = pa; b = pb; end
        4: b = $urandom_range(1, 20);
        5: a = $urandom_range(0, 1000);
        default: ;
      endcase
      issue(op, a, b);
      pa = a; pb = b;
    end

    wait_idle();
    repeat (3) @(negedge clk_i);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside exe and is instantiated inside it. exe launches an operation and holds its stall request to pipe_ctrl until div_unit signals completion.
- exe then forwards result_o as reg_wdata_o into exe_mem.
- Handles the RISC-V divide-by-zero and signed-overflow cases without trapping.

Parameters:
- DATA_WIDTH, 32, operand/result width (equals `RDATA_WIDTH).
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  launch request; sampled only in IDLE.
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- dividend_i  input  DATA_WIDTH  rs1 value; sampled with start_i.
- divisor_i  input  DATA_WIDTH  rs2 value; sampled with start_i.
- flush_i  input  1  abort (driven by ctrl flush_jump).
- busy_o  output  1  high from the cycle after an accepted start through the DONE cycle.
- done_o  output  1  one-cycle pulse; result_o valid in this cycle.
- result_o  output  DATA_WIDTH  quotient or remainder per the latched op.
- stallreq_o  output  1  equals (start_i & IDLE) | (busy_o & ~done_o); exe ORs it into its stall request.

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE; busy_o=0, done_o=0, result_o=0; counter and all datapath registers cleared.
- States: IDLE, CALC, DONE.
- IDLE, start_i=1, flush_i=0: latch op_i and the absolute operand values; record the quotient sign and remainder sign.
  - divisor_i==0: go to DONE next cycle. Quotient = all ones; remainder = dividend_i unmodified.
  - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF: go to DONE next cycle. Quotient = 0x80000000; remainder = 0.
  - Otherwise: go to CALC, counter=0.
- CALC, each cycle: shift {rem, quo} left by 1. Trial-subtract the divisor in a DATA_WIDTH+1-bit subtractor; if non-negative, keep the difference and set the quo LSB. Counter increments.
- CALC exit: after DATA_WIDTH iterations (counter==DATA_WIDTH-1 in the last cycle), go to DONE.
- DONE entry:
  - Apply sign correction. Signed ops: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Register result_o = quotient for DIV/DIVU, remainder for REM/REMU.
- DONE, for one cycle: done_o=1, stallreq_o=0; next state IDLE. start_i is ignored in DONE.
- Latency: normal op, start accepted at cycle T gives done_o at T+DATA_WIDTH+1 (T+33 for 32 bits). Special case gives done_o at T+1.
- result_o holds its value after DONE until the next DONE.
- Start handling: start_i while busy is ignored. Back-to-back ops: exe presents the next start in the IDLE cycle after DONE.
- flush_i=1 in any state: next state IDLE, no done_o, result_o unchanged. flush_i with start_i in IDLE: the start is not accepted.
- Stall interplay: pipe_ctrl stalling id_exe while div_unit is busy is expected. Operands are latched, so input changes during CALC have no effect.

Optional Feature:
- Macro DIV_RESULT_CACHE_EN.
- Defined:
  - Keep the last completed operand pair, its signedness, and both quotient and remainder.
  - A start whose dividend, divisor and signedness match, when the cache is valid, goes directly to DONE next cycle. This covers DIV followed by REM on the same operands.
  - Cache is invalidated by reset and by flush_i during CALC.
- Not defined: no cache registers; every non-special op takes the full DATA_WIDTH+1 cycles.

Test Plan:
- DIVU 100/7: start at T -> done_o at T+33, result_o=14. Then REMU 100/7 -> 2 (at T'+1 with DIV_RESULT_CACHE_EN, T'+33 without).
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
- DIV 5/0 -> done_o at T+1, 0xFFFFFFFF; REM 5/0 -> 5; DIVU 0x80000000/0 -> 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM same -> 0.
- Flush: DIVU 1000/3, flush_i at T+10 -> no done_o, busy_o=0 at T+11. New DIVU 9/3 -> 3 at start+33.
- Reset: rst_i low at T+5 of a DIV -> all outputs 0 immediately; after release, IDLE, and start is accepted normally.
